// File: rtl/counter_gen_pkg.sv
// Shared types and helpers for the parametrised step counter family.
// The bound policy selects what happens when a step would leave [MIN, MAX].
package counter_gen_pkg;

    typedef enum logic [1:0] {
        BP_HOLD,
        BP_CLAMP,
        BP_WRAP
    } bound_policy_e;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnt_step_calc.sv
// Combinational next-value calculator for one enabled step of the counter.
// Works two bits wider than the counter so no intermediate can overflow.
module cnt_step_calc
    import counter_gen_pkg::*;
#(
    parameter int            WIDTH     = 10,
    parameter int            MIN       = -263,
    parameter int            MAX       = 269,
    parameter int            INV       = -47,
    parameter int            UP_STEP   = 4,
    parameter int            DOWN_STEP = 10,
    parameter bound_policy_e POLICY    = BP_HOLD
) (
    input  logic signed [WIDTH-1:0] cnt,
    input  logic                    mode,
    output logic signed [WIDTH-1:0] next,
    output logic                    skip,
    output logic                    bound
);

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] E_MIN   = EW'(MIN);
    localparam logic signed [EW-1:0] E_MAX   = EW'(MAX);
    localparam logic signed [EW-1:0] E_INV   = EW'(INV);
    localparam logic signed [EW-1:0] E_UP    = EW'(UP_STEP);
    localparam logic signed [EW-1:0] E_DOWN  = EW'(DOWN_STEP);
    localparam logic signed [EW-1:0] E_RANGE = EW'(MAX - MIN + 1);

    logic signed [EW-1:0] w_step;
    logic signed [EW-1:0] w_cur;
    logic signed [EW-1:0] w_t;
    logic signed [EW-1:0] w_res;

    // Steps are at most half the range, so one add/subtract of the range is a full modulo.
    function automatic logic signed [EW-1:0] wrapOnce(input logic signed [EW-1:0] t);
        if (t > E_MAX) begin
            return t - E_RANGE;
        end
        if (t < E_MIN) begin
            return t + E_RANGE;
        end
        return t;
    endfunction

    always_comb begin
        w_step = mode ? E_UP : -E_DOWN;
        w_cur  = EW'(cnt);
        w_t    = w_cur + w_step;
        w_res  = w_cur;
        skip   = 1'b0;
        bound  = 1'b0;

        if (w_t == E_INV) begin
            w_t  = w_t + w_step;
            skip = 1'b1;
        end

        if ((w_t > E_MAX) || (w_t < E_MIN)) begin
            bound = 1'b1;
            case (POLICY)
                BP_CLAMP: w_res = mode ? E_MAX : E_MIN;
                BP_WRAP: begin
                    w_res = wrapOnce(w_t);
                    if (w_res == E_INV) begin
                        w_res = wrapOnce(w_res + w_step);
                        skip  = 1'b1;
                    end
                end
                default:  w_res = w_cur;
            endcase
        end else begin
            w_res = w_t;
        end

        next = WIDTH'(w_res);
    end

endmodule

// File: rtl/step_counter_gen.sv
// Parametrised signed up/down step counter with load, bound policy and status pulses.
// Holds the registers, the load range check and the rst > load > en priority mux.
module step_counter_gen
    import counter_gen_pkg::*;
#(
    parameter int            WIDTH     = 10,
    parameter int            RESET_VAL = 17,
    parameter int            MIN       = -263,
    parameter int            MAX       = 269,
    parameter int            INV       = -47,
    parameter int            UP_STEP   = 4,
    parameter int            DOWN_STEP = 10,
    parameter bound_policy_e POLICY    = BP_HOLD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] load_val,
    output logic signed [WIDTH-1:0] cnt,
    output logic                    at_max,
    output logic                    at_min,
    output logic                    bound_hit,
    output logic                    skip_hit,
    output logic                    load_err
);

    localparam logic signed [WIDTH-1:0] L_MIN   = WIDTH'(MIN);
    localparam logic signed [WIDTH-1:0] L_MAX   = WIDTH'(MAX);
    localparam logic signed [WIDTH-1:0] L_INV   = WIDTH'(INV);
    localparam logic signed [WIDTH-1:0] L_RESET = WIDTH'(RESET_VAL);

    // Parameter sanity: a bad instance must not elaborate at all.
    if (!((MIN < INV) && (INV < MAX))) begin : g_chkInv
        $fatal(1, "step_counter_gen: INV must lie strictly between MIN and MAX");
    end
    if (!((MIN <= RESET_VAL) && (RESET_VAL <= MAX) && (RESET_VAL != INV))) begin : g_chkReset
        $fatal(1, "step_counter_gen: RESET_VAL must be legal and differ from INV");
    end
    if (!((UP_STEP > 0) && (DOWN_STEP > 0))) begin : g_chkSteps
        $fatal(1, "step_counter_gen: UP_STEP and DOWN_STEP must be positive");
    end
    if (2 * maxOf(UP_STEP, DOWN_STEP) > (MAX - MIN)) begin : g_chkSpan
        $fatal(1, "step_counter_gen: steps too large for the MIN..MAX range");
    end
    if ((MIN < -(2 ** (WIDTH - 1))) || (MAX > (2 ** (WIDTH - 1)) - 1)) begin : g_chkWidth
        $fatal(1, "step_counter_gen: MIN/MAX not representable in WIDTH bits");
    end

    logic signed [WIDTH-1:0] r_cnt;
    logic                    r_boundHit;
    logic                    r_skipHit;
    logic                    r_loadErr;
    logic signed [WIDTH-1:0] w_next;
    logic                    w_skip;
    logic                    w_bound;
    logic                    w_loadOk;

    cnt_step_calc #(
        .WIDTH     (WIDTH),
        .MIN       (MIN),
        .MAX       (MAX),
        .INV       (INV),
        .UP_STEP   (UP_STEP),
        .DOWN_STEP (DOWN_STEP),
        .POLICY    (POLICY)
    ) u_calc (
        .cnt   (r_cnt),
        .mode  (mode),
        .next  (w_next),
        .skip  (w_skip),
        .bound (w_bound)
    );

    assign w_loadOk = (load_val >= L_MIN) && (load_val <= L_MAX) && (load_val != L_INV);

    // Pulses default low every cycle so each one lasts exactly one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= L_RESET;
            r_boundHit <= 1'b0;
            r_skipHit  <= 1'b0;
            r_loadErr  <= 1'b0;
        end else begin
            r_boundHit <= 1'b0;
            r_skipHit  <= 1'b0;
            r_loadErr  <= 1'b0;
            if (load) begin
                if (w_loadOk) begin
                    r_cnt <= load_val;
                end else begin
                    r_loadErr <= 1'b1;
                end
            end else if (en) begin
                r_cnt      <= w_next;
                r_boundHit <= w_bound;
                r_skipHit  <= w_skip;
            end
        end
    end

    assign cnt       = r_cnt;
    assign at_max    = (r_cnt == L_MAX);
    assign at_min    = (r_cnt == L_MIN);
    assign bound_hit = r_boundHit;
    assign skip_hit  = r_skipHit;
    assign load_err  = r_loadErr;

endmodule

// File: tb/tb_step_counter_gen.sv
// Scoreboard bench: HOLD, CLAMP and WRAP instances share stimulus; a reference
// model pushes expected results and a monitor compares them after each edge.
module tb_step_counter_gen;
    import counter_gen_pkg::*;

    localparam int T_MIN = -263;
    localparam int T_MAX = 269;
    localparam int T_INV = -47;

    typedef struct {
        int cnt;
        bit bnd;
        bit skp;
        bit lerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic mode = 1'b0;
    logic load = 1'b0;
    logic signed [9:0] loadVal = '0;

    logic signed [9:0] dCnt [3];
    logic dMax [3];
    logic dMin [3];
    logic dBnd [3];
    logic dSkp [3];
    logic dErr [3];

    int checks = 0;
    int failures = 0;
    int mCnt [3];
    exp_t expQ [$];

    always #5 clk = ~clk;

    step_counter_gen #(.POLICY(BP_HOLD)) u_hold (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(loadVal),
        .cnt(dCnt[0]), .at_max(dMax[0]), .at_min(dMin[0]),
        .bound_hit(dBnd[0]), .skip_hit(dSkp[0]), .load_err(dErr[0]));

    step_counter_gen #(.POLICY(BP_CLAMP)) u_clamp (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(loadVal),
        .cnt(dCnt[1]), .at_max(dMax[1]), .at_min(dMin[1]),
        .bound_hit(dBnd[1]), .skip_hit(dSkp[1]), .load_err(dErr[1]));

    step_counter_gen #(.POLICY(BP_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(loadVal),
        .cnt(dCnt[2]), .at_max(dMax[2]), .at_min(dMin[2]),
        .bound_hit(dBnd[2]), .skip_hit(dSkp[2]), .load_err(dErr[2]));

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Positive modulo onto MIN..MAX, straight from the wrap rule.
    function automatic int wrapMod(input int t);
        int r;
        int x;
        r = T_MAX - T_MIN + 1;
        x = (t - T_MIN) % r;
        if (x < 0) x += r;
        return T_MIN + x;
    endfunction

    // Reference model: p = 0 HOLD, 1 CLAMP, 2 WRAP.
    function automatic exp_t modelStep(input int p, input bit rs, input bit ld,
                                       input int lv, input bit e, input bit md);
        exp_t x;
        int s;
        int t;
        x.bnd = 0;
        x.skp = 0;
        x.lerr = 0;
        if (rs) begin
            mCnt[p] = 17;
        end else if (ld) begin
            if (lv >= T_MIN && lv <= T_MAX && lv != T_INV) mCnt[p] = lv;
            else x.lerr = 1;
        end else if (e) begin
            s = md ? 4 : -10;
            t = mCnt[p] + s;
            if (t == T_INV) begin
                t += s;
                x.skp = 1;
            end
            if (t > T_MAX || t < T_MIN) begin
                x.bnd = 1;
                if (p == 1) begin
                    mCnt[p] = md ? T_MAX : T_MIN;
                end else if (p == 2) begin
                    t = wrapMod(t);
                    if (t == T_INV) begin
                        t = wrapMod(t + s);
                        x.skp = 1;
                    end
                    mCnt[p] = t;
                end
            end else begin
                mCnt[p] = t;
            end
        end
        x.cnt = mCnt[p];
        return x;
    endfunction

    task automatic applyStimulus(input bit rs, input bit ld, input logic signed [9:0] lv,
                                 input bit e, input bit md);
        @(negedge clk);
        rst = rs;
        load = ld;
        loadVal = lv;
        en = e;
        mode = md;
        for (int p = 0; p < 3; p++) expQ.push_back(modelStep(p, rs, ld, int'(lv), e, md));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: each edge produces one result per instance, checked against the queue.
    always @(posedge clk) begin
        #1;
        if (expQ.size() >= 3) begin
            for (int p = 0; p < 3; p++) begin
                exp_t x;
                x = expQ.pop_front();
                checkOutput($sformatf("p%0d cnt", p), int'(dCnt[p]), x.cnt);
                checkOutput($sformatf("p%0d at_max", p), int'(dMax[p]), int'(x.cnt == T_MAX));
                checkOutput($sformatf("p%0d at_min", p), int'(dMin[p]), int'(x.cnt == T_MIN));
                checkOutput($sformatf("p%0d bound_hit", p), int'(dBnd[p]), int'(x.bnd));
                checkOutput($sformatf("p%0d skip_hit", p), int'(dSkp[p]), int'(x.skp));
                checkOutput($sformatf("p%0d load_err", p), int'(dErr[p]), int'(x.lerr));
                checkOutput($sformatf("p%0d legal", p),
                            int'(dCnt[p] >= T_MIN && dCnt[p] <= T_MAX && dCnt[p] != T_INV), 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [9:0] lvr;
        bit rs;
        bit ld;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        settle();
        checkOutput("reset cnt", int'(dCnt[0]), 17);
        checkOutput("reset bound", int'(dBnd[0]), 0);

        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("up1", int'(dCnt[0]), 21);
        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("up2", int'(dCnt[0]), 25);
        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("up3", int'(dCnt[0]), 29);

        applyStimulus(0, 1, -10'sd51, 0, 0);
        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("skip up cnt", int'(dCnt[0]), -43);
        checkOutput("skip up pulse", int'(dSkp[0]), 1);
        applyStimulus(0, 1, -10'sd37, 0, 0);
        applyStimulus(0, 0, 0, 1, 0); settle();
        checkOutput("skip down cnt", int'(dCnt[0]), -57);
        checkOutput("skip down pulse", int'(dSkp[0]), 1);

        applyStimulus(0, 1, 10'sd266, 0, 0);
        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("hold 266", int'(dCnt[0]), 266);
        checkOutput("hold bound", int'(dBnd[0]), 1);
        checkOutput("clamp 269", int'(dCnt[1]), 269);
        checkOutput("wrap -263", int'(dCnt[2]), -263);
        checkOutput("wrap at_min", int'(dMin[2]), 1);

        applyStimulus(0, 1, 10'sd265, 0, 0);
        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("reach max", int'(dCnt[0]), 269);
        checkOutput("at_max", int'(dMax[0]), 1);
        applyStimulus(0, 0, 0, 1, 1); settle();
        checkOutput("hold max", int'(dCnt[0]), 269);

        applyStimulus(0, 1, -10'sd260, 0, 0);
        applyStimulus(0, 0, 0, 1, 0); settle();
        checkOutput("hold -260", int'(dCnt[0]), -260);
        checkOutput("wrap 263", int'(dCnt[2]), 263);

        applyStimulus(0, 1, -10'sd47, 1, 1); settle();
        checkOutput("load inv cnt", int'(dCnt[0]), -260);
        checkOutput("load inv err", int'(dErr[0]), 1);
        applyStimulus(0, 1, 10'sd300, 0, 0); settle();
        checkOutput("load 300 cnt", int'(dCnt[0]), -260);
        checkOutput("load 300 err", int'(dErr[0]), 1);
        applyStimulus(0, 1, 10'sd100, 1, 1); settle();
        checkOutput("load over step", int'(dCnt[0]), 100);
        applyStimulus(1, 1, 10'sd50, 1, 1); settle();
        checkOutput("rst priority", int'(dCnt[0]), 17);
        applyStimulus(0, 0, 0, 0, 1); settle();
        checkOutput("idle hold", int'(dCnt[2]), 17);

        for (int i = 0; i < 10000; i++) begin
            rs = ($urandom_range(0, 499) == 0);
            ld = ($urandom_range(0, 7) == 0);
            lvr = 10'($urandom_range(0, 1023));
            applyStimulus(rs, ld, lvr, 1'($urandom), 1'($urandom));
        end
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("queue drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
